// File: rtl/hbus_memctrl_mc.sv
// hbus_memctrl_mc: HyperBus memory controller core, N_CS chip selects.
//
// Translates system memory commands (mi_*) into HyperBus transactions for a
// 2-cycle / 4-byte DDR PHY. Supports fixed or variable (RWDS-sampled) initial
// latency, a programmable CS-high recovery gap and a delayed read strobe.
//
// Ports:
//   clk, rst            system clock, async active-high reset
//   cfg_*               static configuration from the CSR block
//   mi_addr_cs..mi_wmsk command and write-data inputs from the master
//   mi_ready            command accept
//   mi_wack, mi_wlast   write word consumed / final write word
//   mi_rdata, mi_rstb,
//   mi_rlast            read data (straight from phy_dq_in), strobe, last
//   phy_*               PHY clock enables, DQ/RWDS drive and samples, CS_n
//   busy                controller not idle
module hbus_memctrl_mc #(
   parameter int unsigned N_CS  = 4,
   parameter int unsigned LEN_W = 8,
   parameter int unsigned DLY_W = 3,
   localparam int unsigned CS_W = (N_CS > 1) ? $clog2(N_CS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_run,
   input  logic [3:0]       cfg_lat,
   input  logic             cfg_lat_2x,
   input  logic             cfg_var_en,
   input  logic [3:0]       cfg_trwr,
   input  logic [DLY_W-1:0] cfg_cap_dly,
   input  logic [CS_W-1:0]  mi_addr_cs,
   input  logic [31:0]      mi_addr,
   input  logic [LEN_W-1:0] mi_len,
   input  logic             mi_rw,
   input  logic             mi_linear,
   input  logic             mi_valid,
   output logic             mi_ready,
   input  logic [31:0]      mi_wdata,
   input  logic [3:0]       mi_wmsk,
   output logic             mi_wack,
   output logic             mi_wlast,
   output logic [31:0]      mi_rdata,
   output logic             mi_rstb,
   output logic             mi_rlast,
   output logic [1:0]       phy_ck_en,
   input  logic [3:0]       phy_rwds_in,
   output logic [3:0]       phy_rwds_out,
   output logic [1:0]       phy_rwds_oe,
   input  logic [31:0]      phy_dq_in,
   output logic [31:0]      phy_dq_out,
   output logic [1:0]       phy_dq_oe,
   output logic [N_CS-1:0]  phy_cs_n,
   output logic             busy
);

   localparam int unsigned PipeD = (1 << DLY_W) - 1;

   typedef enum logic [2:0] {
      StIdle, StCaMsb, StCaLsb, StLatency, StDataWr, StDataRd, StDone, StRecover
   } state_e;

   state_e             state_q, state_d;
   logic [CS_W-1:0]    cs_q, cs_d;
   logic               rw_q, rw_d;
   logic [47:0]        ca_q, ca_d;
   logic [4:0]         lat_cnt_q, lat_cnt_d;
   logic [LEN_W-1:0]   beat_q, beat_d;
   logic [3:0]         rec_cnt_q, rec_cnt_d;
   logic [3:0]         trwr_q, trwr_d;
   logic [DLY_W-1:0]   cap_dly_q, cap_dly_d;
   logic [PipeD-1:0]   pv_q, pl_q;

   logic               cap_push, cap_last, dbl, cs_active;
   logic [4:0]         lat5;
   logic [DLY_W-1:0]   cap_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cs_q      <= '0;
         rw_q      <= 1'b0;
         ca_q      <= '0;
         lat_cnt_q <= '0;
         beat_q    <= '0;
         rec_cnt_q <= '0;
         trwr_q    <= '0;
         cap_dly_q <= '0;
         pv_q      <= '0;
         pl_q      <= '0;
      end else begin
         state_q   <= state_d;
         cs_q      <= cs_d;
         rw_q      <= rw_d;
         ca_q      <= ca_d;
         lat_cnt_q <= lat_cnt_d;
         beat_q    <= beat_d;
         rec_cnt_q <= rec_cnt_d;
         trwr_q    <= trwr_d;
         cap_dly_q <= cap_dly_d;
         // Capture pipe: stage k holds tokens pushed k+1 cycles ago.
         pv_q[0]   <= cap_push;
         pl_q[0]   <= cap_push & cap_last;
         for (int i = 1; i < int'(PipeD); i++) begin
            pv_q[i] <= pv_q[i-1];
            pl_q[i] <= pl_q[i-1];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cs_d         = cs_q;
      rw_d         = rw_q;
      ca_d         = ca_q;
      lat_cnt_d    = lat_cnt_q;
      beat_d       = beat_q;
      rec_cnt_d    = rec_cnt_q;
      trwr_d       = trwr_q;
      cap_dly_d    = cap_dly_q;
      mi_ready     = 1'b0;
      mi_wack      = 1'b0;
      mi_wlast     = 1'b0;
      phy_ck_en    = 2'b00;
      phy_dq_out   = '0;
      phy_dq_oe    = 2'b00;
      phy_rwds_out = 4'h0;
      phy_rwds_oe  = 2'b00;
      cap_push     = 1'b0;
      cap_last     = 1'b0;
      dbl          = cfg_lat_2x | (cfg_var_en & (|phy_rwds_in));
      lat5         = {1'b0, (cfg_lat == 4'd0) ? 4'd1 : cfg_lat};

      unique case (state_q)
         StIdle: begin
            mi_ready = cfg_run && (rec_cnt_q == 4'd0);
            if (mi_valid && mi_ready) begin
               cs_d    = mi_addr_cs;
               rw_d    = mi_rw;
               beat_d  = mi_len;
               ca_d    = {mi_rw, 1'b0, mi_linear, mi_addr[31:3], 13'h0, mi_addr[2:0]};
               state_d = StCaMsb;
            end
         end
         StCaMsb: begin
            phy_dq_out = ca_q[47:16];
            phy_dq_oe  = 2'b11;
            phy_ck_en  = 2'b11;
            state_d    = StCaLsb;
         end
         StCaLsb: begin
            phy_dq_out = {ca_q[15:0], 16'h0};
            phy_dq_oe  = 2'b10;
            phy_ck_en  = 2'b11;
            // Latency and the per-transaction config are frozen here.
            lat_cnt_d  = (dbl ? (lat5 << 1) : lat5) - 5'd1;
            trwr_d     = cfg_trwr;
            cap_dly_d  = cfg_cap_dly;
            state_d    = StLatency;
         end
         StLatency: begin
            phy_ck_en = 2'b11;
            if (lat_cnt_q == 5'd0) begin
               state_d = rw_q ? StDataRd : StDataWr;
            end else begin
               lat_cnt_d = lat_cnt_q - 5'd1;
            end
         end
         StDataWr: begin
            phy_ck_en    = 2'b11;
            phy_dq_out   = mi_wdata;
            phy_dq_oe    = 2'b11;
            phy_rwds_out = mi_wmsk;
            phy_rwds_oe  = 2'b11;
            mi_wack      = 1'b1;
            mi_wlast     = (beat_q == '0);
            if (beat_q == '0) state_d = StDone;
            else              beat_d  = beat_q - LEN_W'(1);
         end
         StDataRd: begin
            phy_ck_en = 2'b11;
            cap_push  = 1'b1;
            cap_last  = (beat_q == '0);
            if (beat_q == '0) state_d = StDone;
            else              beat_d  = beat_q - LEN_W'(1);
         end
         StDone: begin
            rec_cnt_d = trwr_q;
            state_d   = (trwr_q != 4'd0) ? StRecover : StIdle;
         end
         StRecover: begin
            if (rec_cnt_q != 4'd0) rec_cnt_d = rec_cnt_q - 4'd1;
            if (rec_cnt_q <= 4'd1) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Read strobe: zero delay bypasses the pipe so it lines up with DATA_RD.
   always_comb begin
      cap_idx = cap_dly_q - DLY_W'(1);
      if (cap_dly_q == '0) begin
         mi_rstb  = cap_push;
         mi_rlast = cap_push & cap_last;
      end else begin
         mi_rstb  = pv_q[cap_idx];
         mi_rlast = pl_q[cap_idx];
      end
   end

   // Out-of-range cs_q matches no bit, so no chip select is asserted.
   always_comb begin
      cs_active = (state_q == StCaMsb) || (state_q == StCaLsb) || (state_q == StLatency) ||
                  (state_q == StDataWr) || (state_q == StDataRd) || (state_q == StDone);
      for (int i = 0; i < int'(N_CS); i++) begin
         phy_cs_n[i] = ~(cs_active && (cs_q == CS_W'(i)));
      end
   end

   assign mi_rdata = phy_dq_in;
   assign busy     = (state_q != StIdle);

endmodule
